rob_cmpl_arbiter: RTL and testbench

- Shares the ROB's single completion port (complete_en/complete_id) between NUM_REQ functional units (ALU, LSU, BRU).
- Each requester has a 1-entry holding buffer.
- A round-robin arbiter picks one buffered completion per cycle and drives it through a registered output stage.
- On branch_mispredict, buffered or in-flight completions younger than the branch are squashed, so no trashed ROB slot is ever marked complete.

---
 rtl/rob_cmpl_arbiter.sv | 114 +++++++++++
 tb/tb_rob_cmpl_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_cmpl_arbiter.sv
// Round-robin completion arbiter: one holding buffer per functional unit feeding the
// ROB's single completion port through a registered stage, with branch-flush squashing.
module rob_cmpl_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DEPTH   = 16,
  parameter int IDW     = 4,
  parameter int GW      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*IDW-1:0] req_id,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [IDW-1:0]         rob_head_id,
  input  logic                   branch_mispredict,
  input  logic [IDW-1:0]         recovery_idx,
  output logic                   complete_en,
  output logic [IDW-1:0]         complete_id,
  output logic [GW-1:0]          grant_idx
);

  function automatic logic [IDW-1:0] age_of(input logic [IDW-1:0] x,
                                             input logic [IDW-1:0] head);
    return IDW'((int'(x) + DEPTH - int'(head)) % DEPTH);
  endfunction

  // recovery_idx itself is the oldest surviving id, so strict greater-than
  function automatic logic younger(input logic [IDW-1:0] x,
                                   input logic [IDW-1:0] head,
                                   input logic [IDW-1:0] rec);
    return age_of(x, head) > age_of(rec, head);
  endfunction

  logic [NUM_REQ-1:0] r_buf_valid;
  logic [IDW-1:0]     r_buf_id [NUM_REQ];
  logic [GW-1:0]      r_rr_ptr;
  logic               r_out_valid;
  logic [IDW-1:0]     r_out_id;
  logic [GW-1:0]      r_out_gidx;

  logic [IDW-1:0]     w_req_id [NUM_REQ];
  logic [NUM_REQ-1:0] w_buf_young;
  logic [NUM_REQ-1:0] w_req_young;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_vld;
  logic [GW-1:0]      w_grant_idx;
  logic [GW-1:0]      w_k;
  int                 w_k_sum;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    assign w_req_id[k]    = req_id[k*IDW +: IDW];
    assign w_buf_young[k] = branch_mispredict && younger(r_buf_id[k], rob_head_id, recovery_idx);
    assign w_req_young[k] = branch_mispredict && younger(w_req_id[k], rob_head_id, recovery_idx);
    assign w_elig[k]      = r_buf_valid[k] && !w_buf_young[k];
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_k_sum     = 0;
    w_k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k_sum = int'(r_rr_ptr) + i;
      if (w_k_sum >= NUM_REQ) w_k_sum = w_k_sum - NUM_REQ;
      w_k = GW'(w_k_sum);
      if (!w_grant_vld && w_elig[w_k]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_k;
      end
    end
    w_grant = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;
  end

  // a granted buffer frees its slot in the same cycle, enabling full-rate issue
  assign req_ready = ~r_buf_valid | w_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_valid <= '0;
      for (int k = 0; k < NUM_REQ; k++) r_buf_id[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_grant[k] || w_buf_young[k]) r_buf_valid[k] <= 1'b0;
        if (req_valid[k] && req_ready[k] && !w_req_young[k]) begin
          r_buf_valid[k] <= 1'b1;
          r_buf_id[k]    <= w_req_id[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_gidx  <= '0;
    end else begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_id   <= r_buf_id[w_grant_idx];
        r_out_gidx <= w_grant_idx;
        r_rr_ptr   <= (w_grant_idx == GW'(NUM_REQ - 1)) ? '0 : w_grant_idx + GW'(1);
      end
    end
  end

  assign complete_en = r_out_valid &&
                       !(branch_mispredict && younger(r_out_id, rob_head_id, recovery_idx));
  assign complete_id = r_out_id;
  assign grant_idx   = r_out_gidx;

endmodule

// File: tb/tb_rob_cmpl_arbiter.sv
// Scoreboard bench for rob_cmpl_arbiter: expected completions are queued as stimulus
// is driven and a negedge monitor pops/compares every complete_en pulse.
module tb_rob_cmpl_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DEPTH   = 16;
  localparam int IDW     = 4;
  localparam int GW      = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*IDW-1:0] req_id;
  logic [NUM_REQ-1:0]     req_ready;
  logic [IDW-1:0]         rob_head_id;
  logic                   branch_mispredict;
  logic [IDW-1:0]         recovery_idx;
  logic                   complete_en;
  logic [IDW-1:0]         complete_id;
  logic [GW-1:0]          grant_idx;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [GW-1:0]  g;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rob_cmpl_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .IDW(IDW), .GW(GW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_id           (req_id),
    .req_ready        (req_ready),
    .rob_head_id      (rob_head_id),
    .branch_mispredict(branch_mispredict),
    .recovery_idx     (recovery_idx),
    .complete_en      (complete_en),
    .complete_id      (complete_id),
    .grant_idx        (grant_idx)
  );

  always @(negedge clk) begin
    if (reset === 1'b1 && complete_en === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_completion id=%0d gidx=%0d (none expected)", complete_id, grant_idx);
      end else begin
        mon_e = q.pop_front();
        if (complete_id !== mon_e.id || grant_idx !== mon_e.g) begin
          n_err++;
          $display("FAIL completion_order got id=%0d gidx=%0d expected id=%0d gidx=%0d",
                   complete_id, grant_idx, mon_e.id, mon_e.g);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid         = '0;
    req_id            = '0;
    rob_head_id       = '0;
    branch_mispredict = 1'b0;
    recovery_idx      = '0;
  endtask

  task automatic set_req(input int k, input logic [IDW-1:0] id);
    req_valid[k]           = 1'b1;
    req_id[k*IDW +: IDW]   = id;
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [GW-1:0] g);
    exp_t e;
    e.id = id;
    e.g  = g;
    q.push_back(e);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    q.delete();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && q.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL rst_en_in_reset got=%b exp=0", complete_en); end
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL rst_en got=%b exp=0", complete_en); end
    n_cmp++; if (complete_id !== 4'd0) begin n_err++; $display("FAIL rst_id got=%0d exp=0", complete_id); end
    n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL rst_gidx got=%0d exp=0", grant_idx); end
    n_cmp++; if (req_ready !== 3'b111) begin n_err++; $display("FAIL rst_ready got=%b exp=111", req_ready); end
    step();
  endtask

  task automatic test_single();
    do_reset();
    push(4'd5, 2'd0);
    set_req(0, 4'd5);
    @(negedge clk);
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL single_ready got=%b exp=1", req_ready[0]); end
    step();
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL single_early got=%b exp=0", complete_en); end
    step();
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b1) begin n_err++; $display("FAIL single_latency got=%b exp=1", complete_en); end
    step();
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL single_one_pulse got=%b exp=0", complete_en); end
    step();
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL single_drain got=%0d left exp=0", q.size()); end
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] exp_rdy [3];
    exp_rdy[0] = 3'b001;
    exp_rdy[1] = 3'b011;
    exp_rdy[2] = 3'b111;
    do_reset();
    push(4'd1, 2'd0);
    push(4'd2, 2'd1);
    push(4'd3, 2'd2);
    set_req(0, 4'd1);
    set_req(1, 4'd2);
    set_req(2, 4'd3);
    step();
    req_valid = '0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i <= 3) begin
        n_cmp++;
        if (req_ready !== exp_rdy[i-1]) begin
          n_err++; $display("FAIL contention_ready cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy[i-1]);
        end
      end
      n_cmp++;
      if (complete_en !== (i >= 2 && i <= 4)) begin
        n_err++; $display("FAIL contention_en cyc=%0d got=%b exp=%b", i, complete_en, (i >= 2 && i <= 4));
      end
      step();
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL contention_drain got=%0d left exp=0", q.size()); end
  endtask

  task automatic test_fairness();
    int idx;
    int cyc;
    logic [NUM_REQ-1:0] rdy;
    do_reset();
    push(4'd0, 2'd0);
    push(4'd9, 2'd2);
    for (int i = 1; i <= 5; i++) push(4'(i), 2'd0);
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 30) begin
      set_req(0, 4'(idx));
      if (cyc == 1) set_req(2, 4'd9);
      rdy = req_ready;
      step();
      if (rdy[0]) idx++;
      if (rdy[2] && req_valid[2]) req_valid[2] = 1'b0;
      cyc++;
    end
    req_valid = '0;
    n_cmp++; if (idx != 6) begin n_err++; $display("FAIL fair_accepts got=%0d exp=6", idx); end
    drain(20);
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL fair_drain got=%0d left exp=0", q.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 4'd2);
    set_req(1, 4'd5);
    set_req(2, 4'd7);
    push(4'd2, 2'd0);
    push(4'd5, 2'd1);
    step();
    req_valid         = '0;
    branch_mispredict = 1'b1;
    recovery_idx      = 4'd5;
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL flush_ready got=%b exp=001", req_ready); end
    step();
    branch_mispredict = 1'b0;
    drain(10);
    repeat (3) step();
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL flush_drain got=%0d left exp=0", q.size()); end

    do_reset();
    rob_head_id = 4'd14;
    set_req(0, 4'd14);
    set_req(1, 4'd1);
    push(4'd14, 2'd0);
    step();
    req_valid         = '0;
    branch_mispredict = 1'b1;
    recovery_idx      = 4'd15;
    set_req(2, 4'd0);
    @(negedge clk);
    n_cmp++; if (req_ready[2] !== 1'b1) begin n_err++; $display("FAIL wrap_young_ready got=%b exp=1", req_ready[2]); end
    step();
    branch_mispredict = 1'b0;
    req_valid         = '0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b111) begin n_err++; $display("FAIL wrap_squashed_ready got=%b exp=111", req_ready); end
    repeat (5) step();
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL wrap_drain got=%0d left exp=0", q.size()); end
  endtask

  task automatic test_out_gate();
    do_reset();
    set_req(2, 4'd7);
    step();
    req_valid = '0;
    step();
    branch_mispredict = 1'b1;
    recovery_idx      = 4'd5;
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL gate_young got=%b exp=0", complete_en); end
    step();
    branch_mispredict = 1'b0;
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL gate_after got=%b exp=0", complete_en); end
    step();
    set_req(2, 4'd7);
    push(4'd7, 2'd2);
    step();
    req_valid = '0;
    step();
    branch_mispredict = 1'b1;
    recovery_idx      = 4'd7;
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b1) begin n_err++; $display("FAIL gate_equal_kept got=%b exp=1", complete_en); end
    step();
    branch_mispredict = 1'b0;
    drain(5);
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL gate_drain got=%0d left exp=0", q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 4'd3);
    set_req(1, 4'd4);
    set_req(2, 4'd6);
    push(4'd3, 2'd0);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    n_cmp++; if (complete_en !== 1'b1) begin n_err++; $display("FAIL arst_pre got=%b exp=1", complete_en); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (complete_en !== 1'b0) begin n_err++; $display("FAIL arst_drop got=%b exp=0", complete_en); end
    n_cmp++; if (req_ready !== 3'b111) begin n_err++; $display("FAIL arst_ready got=%b exp=111", req_ready); end
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (complete_en !== 1'b0) begin n_err++; $display("FAIL arst_quiet cyc=%0d got=%b exp=0", i, complete_en); end
      step();
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL arst_drain got=%0d left exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_flush();
    test_out_gate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
